// File: rtl/seg7_signed_scan.sv
// seg7_signed_scan: signed/unsigned binary to multiplexed 7-segment driver with a serial double-dabble engine
module seg7_signed_scan #(
  parameter int W        = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_CNT = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W-1:0]      n,
  input  logic              signed_mode,
  output logic              busy,
  output logic              done,
  output logic [DIGITS-1:0] led_id,
  output logic [6:0]        out_led
);
  localparam int ND = DIGITS - 1;
  localparam int SW = $clog2(W + 1);
  localparam int CW = SCAN_CNT > 1 ? $clog2(SCAN_CNT) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b1111110;

  function automatic longint p10(input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  generate
    if (p10(ND) <= (longint'(1) << W)) begin : g_bad
      $error("seg7_signed_scan: DIGITS-1 decimal digits cannot hold 2^W");
    end
  endgenerate

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t          state;
  logic            neg;
  logic [W-1:0]    mag;
  logic [4*ND-1:0] bcd, adj;
  logic [SW-1:0]   sc;
  logic [6:0]      disp [DIGITS];
  logic [6:0]      disp_n [DIGITS];
  logic            lead;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            wrap;

  // lead stays high while every digit from the top down to i is zero
  always_comb begin
    for (int i = 0; i < ND; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    lead = 1'b1;
    for (int i = ND - 1; i >= 1; i--) begin
      lead = lead & (bcd[4*i +: 4] == 4'd0);
      disp_n[i] = (BLANK_LZ != 0 && lead) ? BLANK : seg(bcd[4*i +: 4]);
    end
    disp_n[0] = seg(bcd[3:0]);
    disp_n[ND] = neg ? MINUS : BLANK;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      neg   <= 1'b0;
      mag   <= '0;
      bcd   <= '0;
      sc    <= '0;
      disp  <= '{default: BLANK};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SHIFT;
          busy  <= 1'b1;
          neg   <= signed_mode & n[W-1];
          mag   <= (signed_mode & n[W-1]) ? (~n) + W'(1) : n;
          bcd   <= '0;
          sc    <= '0;
        end
        SHIFT: begin
          {bcd, mag} <= {adj, mag} << 1;
          sc <= sc + SW'(1);
          if (sc == SW'(W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          disp  <= disp_n;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  assign wrap = cnt == CW'(SCAN_CNT - 1);

  // outputs follow the current idx so every slot, including the first, lasts SCAN_CNT cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      led_id  <= '1;
      out_led <= BLANK;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      led_id  <= ~(DIGITS'(1) << idx);
      out_led <= disp[idx];
    end
endmodule

// File: tb/tb_seg7_signed_scan.sv
// tb_seg7_signed_scan: model-checked bench for seg7_signed_scan with and without leading-zero blanking
module tb_seg7_signed_scan;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, sm = 1'b0;
  logic [7:0] n = '0;
  logic       busy_a, done_a, busy_b, done_b;
  logic [3:0] led_a, led_b;
  logic [6:0] out_a, out_b;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  seg7_signed_scan #(.W(8), .DIGITS(4), .SCAN_CNT(4), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .signed_mode(sm),
    .busy(busy_a), .done(done_a), .led_id(led_a), .out_led(out_a));
  seg7_signed_scan #(.W(8), .DIGITS(4), .SCAN_CNT(4), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n), .signed_mode(sm),
    .busy(busy_b), .done(done_b), .led_id(led_b), .out_led(out_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b0000001;
      1: seg = 7'b1001111;
      2: seg = 7'b0010010;
      3: seg = 7'b0000110;
      4: seg = 7'b1001100;
      5: seg = 7'b0100100;
      6: seg = 7'b0100000;
      7: seg = 7'b0001111;
      8: seg = 7'b0000000;
      9: seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // expected display as {digit3, digit2, digit1, digit0}
  function automatic logic [27:0] expect_disp(input logic [7:0] v, input logic s, input bit blz);
    bit neg = s && v[7];
    int mag = neg ? 256 - int'(v) : int'(v);
    logic [27:0] r;
    r[27:21] = neg ? 7'b1111110 : 7'b1111111;
    r[20:14] = (blz && mag < 100) ? 7'b1111111 : seg(mag / 100);
    r[13:7]  = (blz && mag < 10) ? 7'b1111111 : seg((mag / 10) % 10);
    r[6:0]   = seg(mag % 10);
    return r;
  endfunction

  int          k, left, slot;
  logic [7:0]  pn;
  logic        psm;
  logic [27:0] mda, mdb;
  logic [3:0]  eled;
  logic [6:0]  eouta, eoutb;
  logic        ebusy, edone;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k = 0; left = 0; mda = '1; mdb = '1;
      eled = '1; eouta = '1; eoutb = '1; ebusy = 1'b0; edone = 1'b0;
    end else begin
      slot = (k / 4) % 4;
      eled = ~(4'b1 << slot);
      eouta = mda[7*slot +: 7];
      eoutb = mdb[7*slot +: 7];
      k++;
      edone = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          mda = expect_disp(pn, psm, 1'b1);
          mdb = expect_disp(pn, psm, 1'b0);
          edone = 1'b1;
        end
      end else if (start) begin
        left = 9; pn = n; psm = sm;
      end
      ebusy = left > 0;
    end

  always @(negedge clk) begin
    chk("led_a", led_a, eled);
    chk("led_b", led_b, eled);
    chk("out_a", out_a, eouta);
    chk("out_b", out_b, eoutb);
    chk("busy_a", busy_a, ebusy);
    chk("busy_b", busy_b, ebusy);
    chk("done_a", done_a, edone);
    chk("done_b", done_b, edone);
    if (rst_n && k > 0) chk("onehot", $countones(~led_a), 1);
  end

  task automatic show(input logic [27:0] ea, input logic [27:0] eb, input string nm);
    @(negedge clk);
    repeat (16) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (led_a == ~(4'b1 << i)) begin
          chk({nm, " digit_a"}, out_a, ea[7*i +: 7]);
          chk({nm, " digit_b"}, out_b, eb[7*i +: 7]);
        end
    end
  endtask

  task automatic conv(input logic [7:0] v, input logic s, input logic [27:0] ea, input logic [27:0] eb, input string nm);
    int c = 0;
    @(negedge clk); start = 1'b1; n = v; sm = s;
    @(negedge clk); start = 1'b0;
    while (!done_a && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " latency"}, c, 9);
    show(ea, eb, nm);
  endtask

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    chk("reset led", led_a, 4'hF);
    chk("reset out", out_a, 7'h7F);
    chk("reset busy", busy_a, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first led", led_a, 4'b1110);
    chk("first out", out_a, 7'h7F);
    chk("model -128", expect_disp(8'h80, 1'b1, 1'b1), {7'h7E, 7'h4F, 7'h12, 7'h00});
    conv(8'h80, 1'b1, {7'h7E, 7'h4F, 7'h12, 7'h00}, {7'h7E, 7'h4F, 7'h12, 7'h00}, "m128");
    conv(8'hFF, 1'b0, {7'h7F, 7'h12, 7'h24, 7'h24}, {7'h7F, 7'h12, 7'h24, 7'h24}, "u255");
    conv(8'hFF, 1'b1, {7'h7E, 7'h7F, 7'h7F, 7'h4F}, {7'h7E, 7'h01, 7'h01, 7'h4F}, "m1");
    conv(8'h00, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h01}, {7'h7F, 7'h01, 7'h01, 7'h01}, "zero");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async led", led_a, 4'hF);
    chk("async out", out_a, 7'h7F);
    chk("async busy", busy_a, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk); start = 1'b1; n = 8'd57; sm = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; n = 8'd99;
    @(negedge clk); start = 1'b0;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      nd += int'(done_a);
    end
    chk("ignore done count", nd, 1);
    show({7'h7F, 7'h7F, 7'h24, 7'h0F}, {7'h7F, 7'h01, 7'h24, 7'h0F}, "ignore");
    @(negedge clk); start = 1'b1; n = 8'd200; sm = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      nd += int'(done_a);
    end
    chk("abort done count", nd, 0);
    show(28'hFFFFFFF, 28'hFFFFFFF, "abort");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
